fc_spk_writer: RTL and testbench
================================

# fc_spk_writer

Post-synaptic spike writer for a fully connected SNN layer. It collects the per-time-step spike vectors produced by an EC_SIZE-wide group of neuron units, which arrive neuron-group-major and time-step-minor. It repacks them into time-step-major spike-train words in the post-synaptic spike RAM, laid out exactly as the next layer's event controller reads them (one FRAME_SIZE word per time step and channel). When the RAM image is complete it raises `post_syn_RAM_loaded` and holds it until the consumer releases it.

## Interface
Parameters:
- TIME_STEPS, 10, time steps per image
- EC_SIZE, 4, neurons evaluated in parallel; LAYER_SIZE % EC_SIZE == 0 is required
- LAYER_SIZE, 32, neurons in this layer
- FRAME_SIZE, 16, bits per RAM word (next layer's input frame)
- OUT_CH, ceil(LAYER_SIZE/FRAME_SIZE), words per time step (derived)
- RAM_DEPTH, TIME_STEPS*OUT_CH (derived); RAM_ADDR_W = $clog2(RAM_DEPTH)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- spk_valid  in  1  `spk_in` holds one time step's spikes for the current group
- spk_in  in  EC_SIZE  spike of neuron group*EC_SIZE+i on bit i
- in_ready  out  1  high only in COLLECT
- ram_we  out  1  RAM write strobe
- ram_addr  out  RAM_ADDR_W  write address = t*OUT_CH + ch
- ram_wdata  out  FRAME_SIZE  bit b = spike of neuron ch*FRAME_SIZE+b at step t
- post_syn_RAM_loaded  out  1  RAM image complete
- ram_release  in  1  consumer finished reading; returns the block to IDLE
- spk_total  out  $clog2(TIME_STEPS*LAYER_SIZE+1)  spikes collected in the current image
- overflow  out  1  sticky: a `spk_valid` arrived while `in_ready` was low

## Operation
- States: IDLE, COLLECT, FLUSH, DONE.
- IDLE:
  - The bit buffer (TIME_STEPS x OUT_CH x FRAME_SIZE) and all counters are zero.
  - Moves to COLLECT on the next cycle unconditionally; IDLE lasts exactly one cycle after reset or release.
- COLLECT:
  - On each `spk_valid`, `spk_in[i]` is written to buffer bit (t_cnt, group*EC_SIZE+i), and `spk_total` increases by the popcount of `spk_in`.
  - t_cnt increments on each valid and wraps to 0 after TIME_STEPS-1; on wrap, group increments.
  - After the valid with group = LAYER_SIZE/EC_SIZE-1 and t_cnt = TIME_STEPS-1, the state moves to FLUSH.
- FLUSH:
  - One word per cycle, addr 0 to RAM_DEPTH-1 in order: `ram_we`=1, `ram_wdata` = buffer word.
  - Padding bits of the last channel (neuron index ≥ LAYER_SIZE) are written as 0.
  - After the last word the state moves to DONE.
- DONE: `post_syn_RAM_loaded`=1. On `ram_release`, the state moves to IDLE and the buffer, counters and `spk_total` clear.
- `ram_release` outside DONE is ignored.
- `spk_valid` outside COLLECT:
  - The data is dropped, `overflow` is set, and no buffer or counter changes.
  - `overflow` clears only on rst.

## Timing
- Reset values:
  - Outputs: `in_ready`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0, `post_syn_RAM_loaded`=0, `spk_total`=0, `overflow`=0.
  - State is IDLE and the buffer is zero.
- All outputs are registered.
- `in_ready` rises 1 cycle after reset deassert or after the release edge.
- A valid is captured on the edge where it is sampled high with `in_ready`=1; back-to-back valids are allowed every cycle.
- The first `ram_we` is asserted the cycle after the final capture edge. `ram_we` then stays high for exactly RAM_DEPTH consecutive cycles.
- `post_syn_RAM_loaded` rises the cycle after the last write and stays high until the edge sampling `ram_release`=1; it is low the following cycle.
- rst mid-COLLECT or mid-FLUSH aborts immediately: no further writes, all state returns to reset values. Partial RAM contents are not valid.
- Input ordering is not checked; the block trusts the upstream counter sequence.

## Structure
- Shared package `snn_pkg`:
  - `writer_state_t` enum {IDLE, COLLECT, FLUSH, DONE}.
  - Derived-constant functions for OUT_CH and RAM_DEPTH.
- Sub-module `spk_frame_buffer`:
  - Storage of TIME_STEPS*OUT_CH words of FRAME_SIZE bits.
  - EC_SIZE-bit write at a (t, neuron offset) position.
  - Full-word read by address.
  - Synchronous clear.
- The top level holds the FSM, counters, popcount and overflow flag.

## Test plan
- **All-zero image:** defaults, 80 valids with `spk_in`=0 -> 20 writes of 0x0000 at addr 0..19, `spk_total`=0, loaded the cycle after addr 19.
- **Single spike:** group 5, t=3, `spk_in`=4'b0010 (neuron 21) -> only addr 3*2+1=7 nonzero, data 0x0020; `spk_total`=1.
- **All-ones image:** every `spk_in`=4'hF -> every word 0xFFFF, `spk_total`=320. Repeat with LAYER_SIZE=20, EC_SIZE=4: words for ch=1 read 0x000F (padding zero).
- **Backpressure:** a `spk_valid` pulse during FLUSH and another during DONE -> data dropped, `overflow`=1, RAM contents unchanged; `overflow` stays 1 after release until rst.
- **Release handshake:**
  - Hold `ram_release` low 50 cycles in DONE -> loaded stays 1.
  - Pulse release -> loaded 0 the next cycle, `in_ready` 1 after IDLE.
  - A second image with different data writes correctly, with no residue from the first.
- **Reset mid-FLUSH:** assert rst while writing addr 10 -> `ram_we`=0 the next cycle, all outputs at reset values, and a following full image completes normally.

Source files
------------

// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared writer state type and derived layer constants
package snn_pkg;

  typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, DONE} writer_state_t;

  function automatic int calc_out_ch(input int layer_size, input int frame_size);
    return (layer_size + frame_size - 1) / frame_size;
  endfunction

  function automatic int calc_ram_depth(input int time_steps, input int layer_size,
                                        input int frame_size);
    return time_steps * calc_out_ch(layer_size, frame_size);
  endfunction

endpackage

// File: rtl/spk_frame_buffer.sv
// rtl/spk_frame_buffer.sv - time-step-major spike bit buffer with word readout
module spk_frame_buffer #(
  parameter int EC_SIZE    = 4,
  parameter int FRAME_SIZE = 16,
  parameter int OUT_CH     = 2,
  parameter int RAM_DEPTH  = 20,
  parameter int T_W        = 4,
  parameter int N_W        = 5,
  parameter int ADDR_W     = 5
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [T_W-1:0]        wr_t,
  input  logic [N_W-1:0]        wr_off,
  input  logic [EC_SIZE-1:0]    wr_data,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [FRAME_SIZE-1:0] rd_word
);

  localparam int ROW_BITS   = OUT_CH * FRAME_SIZE;
  localparam int TOTAL_BITS = RAM_DEPTH * FRAME_SIZE;
  localparam int BIT_W      = $clog2(TOTAL_BITS);

  // Flat bit index t*ROW_BITS + neuron makes word address a land on bits a*FRAME_SIZE.
  logic [TOTAL_BITS-1:0] mem_q, mem_d;
  logic [BIT_W-1:0]      wr_base, rd_base;

  assign wr_base = BIT_W'(wr_t) * BIT_W'(ROW_BITS) + BIT_W'(wr_off);
  assign rd_base = BIT_W'(rd_addr) * BIT_W'(FRAME_SIZE);

  always_comb begin
    mem_d = mem_q;
    if (clr) begin
      mem_d = '0;
    end else if (wr_en) begin
      mem_d[wr_base +: EC_SIZE] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Read sees the write landing this cycle, so the final capture can feed word 0.
  assign rd_word = mem_d[rd_base +: FRAME_SIZE];

endmodule

// File: rtl/fc_spk_writer.sv
// rtl/fc_spk_writer.sv - repacks group-major spike vectors into time-step-major RAM words
module fc_spk_writer
  import snn_pkg::*;
#(
  parameter int TIME_STEPS = 10,
  parameter int EC_SIZE    = 4,
  parameter int LAYER_SIZE = 32,
  parameter int FRAME_SIZE = 16,
  localparam int OUT_CH     = calc_out_ch(LAYER_SIZE, FRAME_SIZE),
  localparam int RAM_DEPTH  = calc_ram_depth(TIME_STEPS, LAYER_SIZE, FRAME_SIZE),
  localparam int RAM_ADDR_W = $clog2(RAM_DEPTH),
  localparam int SPK_W      = $clog2(TIME_STEPS * LAYER_SIZE + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spk_valid,
  input  logic [EC_SIZE-1:0]    spk_in,
  output logic                  in_ready,
  output logic                  ram_we,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [FRAME_SIZE-1:0] ram_wdata,
  output logic                  post_syn_RAM_loaded,
  input  logic                  ram_release,
  output logic [SPK_W-1:0]      spk_total,
  output logic                  overflow
);

  localparam int N_GROUPS = LAYER_SIZE / EC_SIZE;
  localparam int T_W = (TIME_STEPS > 1) ? $clog2(TIME_STEPS) : 1;
  localparam int G_W = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
  localparam int N_W = (LAYER_SIZE > 1) ? $clog2(LAYER_SIZE) : 1;
  localparam logic [T_W-1:0]        T_LAST    = T_W'(TIME_STEPS - 1);
  localparam logic [G_W-1:0]        G_LAST    = G_W'(N_GROUPS - 1);
  localparam logic [RAM_ADDR_W-1:0] ADDR_LAST = RAM_ADDR_W'(RAM_DEPTH - 1);

  writer_state_t         state, next_state;
  logic [T_W-1:0]        t_cnt;
  logic [G_W-1:0]        grp_cnt;
  logic                  capture, last_capture, release_evt;
  logic                  in_ready_d, ram_we_d, loaded_d;
  logic [RAM_ADDR_W-1:0] ram_addr_d;
  logic [FRAME_SIZE-1:0] ram_wdata_d, rd_word;
  logic [N_W-1:0]        wr_off;

  function automatic logic [SPK_W-1:0] popcount(input logic [EC_SIZE-1:0] v);
    logic [SPK_W-1:0] c;
    c = '0;
    for (int i = 0; i < EC_SIZE; i++) begin
      c = c + SPK_W'(v[i]);
    end
    return c;
  endfunction

  // in_ready is a registered copy of (state == COLLECT), so it gates capture directly.
  assign capture      = spk_valid && in_ready;
  assign last_capture = capture && (t_cnt == T_LAST) && (grp_cnt == G_LAST);
  assign release_evt  = (state == DONE) && ram_release;
  assign wr_off       = N_W'(grp_cnt) * N_W'(EC_SIZE);

  spk_frame_buffer #(
    .EC_SIZE    (EC_SIZE),
    .FRAME_SIZE (FRAME_SIZE),
    .OUT_CH     (OUT_CH),
    .RAM_DEPTH  (RAM_DEPTH),
    .T_W        (T_W),
    .N_W        (N_W),
    .ADDR_W     (RAM_ADDR_W)
  ) u_buf (
    .clk     (clk),
    .clr     (rst || release_evt),
    .wr_en   (capture),
    .wr_t    (t_cnt),
    .wr_off  (wr_off),
    .wr_data (spk_in),
    .rd_addr (ram_addr_d),
    .rd_word (rd_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      in_ready            <= 1'b0;
      ram_we              <= 1'b0;
      ram_addr            <= '0;
      ram_wdata           <= '0;
      post_syn_RAM_loaded <= 1'b0;
    end else begin
      state               <= next_state;
      in_ready            <= in_ready_d;
      ram_we              <= ram_we_d;
      ram_addr            <= ram_addr_d;
      ram_wdata           <= ram_wdata_d;
      post_syn_RAM_loaded <= loaded_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = COLLECT;
      COLLECT: if (last_capture) next_state = FLUSH;
      FLUSH:   if (ram_addr == ADDR_LAST) next_state = DONE;
      DONE:    if (ram_release) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are computed for the coming cycle and registered above.
  always_comb begin
    in_ready_d  = (next_state == COLLECT);
    ram_we_d    = (next_state == FLUSH);
    loaded_d    = (next_state == DONE);
    ram_addr_d  = '0;
    if ((state == FLUSH) && (next_state == FLUSH)) begin
      ram_addr_d = ram_addr + RAM_ADDR_W'(1);
    end
    ram_wdata_d = ram_we_d ? rd_word : '0;
  end

  always_ff @(posedge clk) begin
    if (rst || release_evt) begin
      t_cnt     <= '0;
      grp_cnt   <= '0;
      spk_total <= '0;
    end else if (capture) begin
      spk_total <= spk_total + popcount(spk_in);
      if (t_cnt == T_LAST) begin
        t_cnt   <= '0;
        grp_cnt <= grp_cnt + G_W'(1);
      end else begin
        t_cnt <= t_cnt + T_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (spk_valid && !in_ready) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fc_spk_writer.sv
// tb/tb_fc_spk_writer.sv - directed self-checking bench for fc_spk_writer
`timescale 1ns/1ps
module tb_fc_spk_writer;

  localparam int TS = 10, EC = 4, LS = 32, FS = 16, OC = 2, DEPTH = 20, NG = LS / EC;
  localparam int LS2 = 20, NG2 = LS2 / EC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spk_valid = 1'b0, ram_release = 1'b0;
  logic [EC-1:0] spk_in = '0;
  logic in_ready, ram_we, loaded, overflow;
  logic [4:0] ram_addr;
  logic [FS-1:0] ram_wdata;
  logic [8:0] spk_total;

  logic spk_valid2 = 1'b0, ram_release2 = 1'b0;
  logic [EC-1:0] spk_in2 = '0;
  logic in_ready2, ram_we2, loaded2, overflow2;
  logic [4:0] ram_addr2;
  logic [FS-1:0] ram_wdata2;
  logic [7:0] spk_total2;

  int n_checks = 0;
  int n_pass = 0;

  logic [LS-1:0] img [TS];
  logic [FS-1:0] ram_model [DEPTH];
  logic [FS-1:0] ram_model2 [DEPTH];
  int wr_cnt, wr_cnt2;
  logic model_clr = 1'b0;

  always #5 clk = ~clk;

  fc_spk_writer #(.TIME_STEPS(TS), .EC_SIZE(EC), .LAYER_SIZE(LS), .FRAME_SIZE(FS)) dut (
    .clk(clk), .rst(rst), .spk_valid(spk_valid), .spk_in(spk_in), .in_ready(in_ready),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .post_syn_RAM_loaded(loaded), .ram_release(ram_release),
    .spk_total(spk_total), .overflow(overflow)
  );

  fc_spk_writer #(.TIME_STEPS(TS), .EC_SIZE(EC), .LAYER_SIZE(LS2), .FRAME_SIZE(FS)) dut20 (
    .clk(clk), .rst(rst), .spk_valid(spk_valid2), .spk_in(spk_in2), .in_ready(in_ready2),
    .ram_we(ram_we2), .ram_addr(ram_addr2), .ram_wdata(ram_wdata2),
    .post_syn_RAM_loaded(loaded2), .ram_release(ram_release2),
    .spk_total(spk_total2), .overflow(overflow2)
  );

  // RAM models: record every write strobe of each DUT
  always @(posedge clk) begin
    if (model_clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        ram_model[i]  <= 16'hDEAD;
        ram_model2[i] <= 16'hDEAD;
      end
      wr_cnt  <= 0;
      wr_cnt2 <= 0;
    end else begin
      if (ram_we) begin
        ram_model[ram_addr] <= ram_wdata;
        wr_cnt <= wr_cnt + 1;
      end
      if (ram_we2) begin
        ram_model2[ram_addr2] <= ram_wdata2;
        wr_cnt2 <= wr_cnt2 + 1;
      end
    end
  end

  function automatic logic [FS-1:0] exp_word(input int a);
    logic [LS-1:0] row;
    row = img[a / OC];
    return row[(a % OC) * FS +: FS];
  endfunction

  function automatic int total_exp();
    int s = 0;
    for (int t = 0; t < TS; t++) s += $countones(img[t]);
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_image();
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL send_ready: in_ready=%b want 1", in_ready);
    else n_pass++;
    model_clr = 1'b1;
    tick();
    model_clr = 1'b0;
    for (int g = 0; g < NG; g++) begin
      for (int t = 0; t < TS; t++) begin
        spk_valid = 1'b1;
        spk_in = img[t][g * EC +: EC];
        tick();
      end
    end
    spk_valid = 1'b0;
    spk_in = '0;
  endtask

  // Entered just after the final capture edge; walks the whole flush.
  task automatic run_flush(input int inject_at);
    int seq_bad = 0;
    int img_bad = 0;
    n_checks++;
    if (ram_we !== 1'b1 || ram_addr !== 5'd0)
      $display("FAIL first_write: we=%b addr=%0d want we=1 addr=0", ram_we, ram_addr);
    else n_pass++;
    for (int i = 0; i < DEPTH; i++) begin
      if (ram_we !== 1'b1 || ram_addr !== 5'(i) || loaded !== 1'b0) seq_bad++;
      if (i == inject_at) begin
        spk_valid = 1'b1;
        spk_in = 4'hF;
      end
      tick();
      spk_valid = 1'b0;
      spk_in = '0;
    end
    n_checks++;
    if (seq_bad !== 0) $display("FAIL flush_seq: bad cycles=%0d want 0", seq_bad);
    else n_pass++;
    n_checks++;
    if (loaded !== 1'b1 || ram_we !== 1'b0)
      $display("FAIL loaded_rise: loaded=%b we=%b want loaded=1 we=0", loaded, ram_we);
    else n_pass++;
    n_checks++;
    if (wr_cnt !== DEPTH) $display("FAIL write_count: got %0d want %0d", wr_cnt, DEPTH);
    else n_pass++;
    for (int a = 0; a < DEPTH; a++) if (ram_model[a] !== exp_word(a)) img_bad++;
    n_checks++;
    if (img_bad !== 0) $display("FAIL ram_image: bad words=%0d want 0 (addr0 got %h want %h)",
                                img_bad, ram_model[0], exp_word(0));
    else n_pass++;
    n_checks++;
    if (spk_total !== 9'(total_exp()))
      $display("FAIL spk_total: got %0d want %0d", spk_total, total_exp());
    else n_pass++;
  endtask

  task automatic do_release();
    ram_release = 1'b1;
    tick();
    ram_release = 1'b0;
    n_checks++;
    if (loaded !== 1'b0 || spk_total !== 9'd0)
      $display("FAIL release: loaded=%b total=%0d want 0 0", loaded, spk_total);
    else n_pass++;
    tick();
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL ready_after_idle: got %b want 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({in_ready, ram_we, ram_addr, ram_wdata, loaded, spk_total, overflow} !== '0)
      $display("FAIL reset_outputs: rdy=%b we=%b addr=%0d wd=%h ld=%b tot=%0d ovf=%b want all 0",
               in_ready, ram_we, ram_addr, ram_wdata, loaded, spk_total, overflow);
    else n_pass++;
    rst = 1'b0;
    tick();
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_all_zero();
    for (int t = 0; t < TS; t++) img[t] = '0;
    send_image();
    run_flush(-1);
    n_checks++;
    if (ram_model[19] !== 16'h0000 || spk_total !== 9'd0)
      $display("FAIL zero_image: addr19=%h total=%0d want 0000 0", ram_model[19], spk_total);
    else n_pass++;
    do_release();
  endtask

  task automatic test_single_spike();
    int nz = 0;
    for (int t = 0; t < TS; t++) img[t] = '0;
    img[3][21] = 1'b1;
    send_image();
    run_flush(-1);
    for (int a = 0; a < DEPTH; a++) if (ram_model[a] !== 16'h0000) nz++;
    n_checks++;
    if (ram_model[7] !== 16'h0020 || nz !== 1 || spk_total !== 9'd1)
      $display("FAIL single_spike: addr7=%h nonzero=%0d total=%0d want 0020 1 1",
               ram_model[7], nz, spk_total);
    else n_pass++;
    do_release();
  endtask

  task automatic test_all_ones_hold();
    int held = 0;
    for (int t = 0; t < TS; t++) img[t] = '1;
    send_image();
    run_flush(-1);
    n_checks++;
    if (ram_model[0] !== 16'hFFFF || ram_model[19] !== 16'hFFFF || spk_total !== 9'd320)
      $display("FAIL all_ones: addr0=%h addr19=%h total=%0d want FFFF FFFF 320",
               ram_model[0], ram_model[19], spk_total);
    else n_pass++;
    repeat (50) begin
      tick();
      if (loaded === 1'b1 && in_ready === 1'b0 && ram_we === 1'b0) held++;
    end
    n_checks++;
    if (held !== 50) $display("FAIL release_hold: loaded cycles=%0d want 50", held);
    else n_pass++;
    do_release();
  endtask

  task automatic test_backpressure();
    for (int t = 0; t < TS; t++) img[t] = 32'h8421_1248 ^ (32'h0000_0F0F << t);
    n_checks++;
    if (overflow !== 1'b0) $display("FAIL ovf_before: got %b want 0", overflow);
    else n_pass++;
    send_image();
    run_flush(5);
    n_checks++;
    if (overflow !== 1'b1) $display("FAIL ovf_flush: got %b want 1", overflow);
    else n_pass++;
    spk_valid = 1'b1;
    spk_in = 4'hF;
    tick();
    spk_valid = 1'b0;
    spk_in = '0;
    tick();
    n_checks++;
    if (loaded !== 1'b1 || wr_cnt !== DEPTH || spk_total !== 9'(total_exp()))
      $display("FAIL ovf_done: loaded=%b writes=%0d total=%0d want 1 %0d %0d",
               loaded, wr_cnt, spk_total, DEPTH, total_exp());
    else n_pass++;
    do_release();
    tick();
    n_checks++;
    if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < TS; t++) img[t] = (32'h1 << (t * 3)) | (32'h8000_0000 >> t);
    send_image();
    run_flush(-1);
    n_checks++;
    if (ram_model[0] !== 16'h0001 || ram_model[1] !== 16'h8000)
      $display("FAIL second_image: addr0=%h addr1=%h want 0001 8000", ram_model[0], ram_model[1]);
    else n_pass++;
    do_release();
  endtask

  task automatic test_reset_mid_flush();
    for (int t = 0; t < TS; t++) img[t] = 32'hF0F0_1234 + t;
    send_image();
    repeat (10) tick();
    n_checks++;
    if (ram_addr !== 5'd10 || ram_we !== 1'b1)
      $display("FAIL midflush_pos: addr=%0d we=%b want 10 1", ram_addr, ram_we);
    else n_pass++;
    rst = 1'b1;
    tick();
    n_checks++;
    if ({in_ready, ram_we, ram_addr, ram_wdata, loaded, spk_total, overflow} !== '0)
      $display("FAIL midflush_reset: rdy=%b we=%b addr=%0d wd=%h ld=%b tot=%0d ovf=%b want all 0",
               in_ready, ram_we, ram_addr, ram_wdata, loaded, spk_total, overflow);
    else n_pass++;
    rst = 1'b0;
    tick();
    for (int t = 0; t < TS; t++) img[t] = 32'h0F0F_A5A5 ^ (32'h3 << (2 * t));
    send_image();
    run_flush(-1);
    do_release();
  endtask

  task automatic test_layer20();
    int bad = 0;
    model_clr = 1'b1;
    tick();
    model_clr = 1'b0;
    for (int i = 0; i < NG2 * TS; i++) begin
      spk_valid2 = 1'b1;
      spk_in2 = 4'hF;
      tick();
    end
    spk_valid2 = 1'b0;
    spk_in2 = '0;
    repeat (DEPTH) tick();
    n_checks++;
    if (loaded2 !== 1'b1 || wr_cnt2 !== DEPTH)
      $display("FAIL l20_done: loaded=%b writes=%0d want 1 %0d", loaded2, wr_cnt2, DEPTH);
    else n_pass++;
    for (int a = 0; a < DEPTH; a += 2) begin
      if (ram_model2[a] !== 16'hFFFF) bad++;
      if (ram_model2[a + 1] !== 16'h000F) bad++;
    end
    n_checks++;
    if (bad !== 0 || spk_total2 !== 8'd200)
      $display("FAIL l20_padding: bad words=%0d addr1=%h total=%0d want 0 000F 200",
               bad, ram_model2[1], spk_total2);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_single_spike();
    test_all_ones_hold();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_flush();
    test_layer20();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
